button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 120000, meaning consecutive CLK cycles a changed input must hold stable before it is accepted (10 ms at 12 MHz).
REQ-002 SHALL have parameter CNT_W, default 17, meaning debounce counter width; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have one clock and an asynchronous active-low reset:
CLK  input  1  system clock, all logic on its rising edge
RST_N  input  1  asynchronous active-low reset
REQ-004 SHALL have the button inputs:
BTN_N  input  1  user button, low = pressed, asynchronous to CLK
BTN1  input  1  button 1, high = pressed, asynchronous to CLK
BTN2  input  1  button 2, high = pressed, asynchronous to CLK
BTN3  input  1  button 3, high = pressed, asynchronous to CLK
REQ-005 SHALL have the outputs:
BTN_STATE  output  4  debounced pressed level; bit0 = BTN_N, bits 1..3 = BTN1..BTN3
PRESS  output  4  one-cycle pulse per bit on an accepted press
RELEASE  output  4  one-cycle pulse per bit on an accepted release
PRESS_COUNT  output  8  running total of accepted presses, all buttons

Function
REQ-006 SHALL normalise inputs so that internal 1 = pressed (BTN_N inverted; BTN1..3 unchanged).
REQ-007 SHALL pass each normalised input through a 2-flop synchroniser; the debounce logic uses only the second flop's output.
REQ-008 SHALL keep, per button, a counter that clears in any cycle where the synchronised value equals BTN_STATE, and increments otherwise.
REQ-009 SHALL toggle BTN_STATE[i] on the edge where button i's counter reaches DEBOUNCE_CYCLES-1 while still mismatched, and clear that counter on the same edge.
- A mismatch of fewer than DEBOUNCE_CYCLES consecutive cycles SHALL leave BTN_STATE unchanged (glitch rejected).
- A single matching cycle SHALL restart the count.
REQ-010 SHALL make latency, from a raw input change to BTN_STATE update, exactly 2 + DEBOUNCE_CYCLES CLK edges for a clean edge.
REQ-011 SHALL register PRESS[i] high for exactly the one cycle in which BTN_STATE[i] first reads 1, and RELEASE[i] for the cycle in which it first reads 0; PRESS[i] and RELEASE[i] SHALL never be high together.
REQ-012 SHALL update PRESS_COUNT one cycle after the PRESS pulses, adding the number of PRESS bits set in that cycle (0..4), modulo 256 (255+1 wraps to 0, no saturation).
REQ-013 SHALL debounce all four buttons independently; simultaneous events on different buttons SHALL all be reported in the same cycle.
REQ-014 SHALL contain no combinational path from any input to any output.

Reset
REQ-015 While RST_N=0, SHALL hold synchronisers, counters, BTN_STATE, PRESS, RELEASE and PRESS_COUNT at 0 (unpressed), asynchronously.
REQ-016 SHALL NOT emit a PRESS or RELEASE pulse on the release of reset; a button held through reset SHALL be reported pressed (with one PRESS pulse) 2 + DEBOUNCE_CYCLES edges after RST_N rises.
REQ-017 Reset asserted mid-debounce SHALL discard the partial count.

Verification (DEBOUNCE_CYCLES=4)
REQ-018 Clean press: BTN1 0->1 and held -> BTN_STATE[1]=1 at edge 6, PRESS=4'b0010 for one cycle, PRESS_COUNT=1 one cycle later.
REQ-019 Glitch: BTN2 high for 3 cycles then low -> BTN_STATE, PRESS and PRESS_COUNT unchanged at 0.
REQ-020 Bounce: BTN_N toggles each cycle for 10 cycles then held low -> exactly one PRESS[0] pulse, 6 edges after the final stable edge.
REQ-021 Simultaneous: BTN1, BTN2 and BTN3 pressed together with PRESS_COUNT=254 -> PRESS=4'b1110 in one cycle, PRESS_COUNT=1 (wrap).
REQ-022 Release: held BTN3 released -> RELEASE=4'b1000 for one cycle, BTN_STATE[3]=0, PRESS_COUNT unchanged.
REQ-023 Reset: RST_N pulsed low while BTN1 held and mid-count -> all outputs 0 immediately; after release, one PRESS[1] pulse at edge 6 and PRESS_COUNT=1.

Source files
------------

// File: rtl/button_debounce.sv
// Four-button debouncer: 2-flop synchronisers, per-button stability counters,
// debounced levels, one-cycle press/release pulses and a running press total.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_N,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  output logic [3:0] BTN_STATE,
  output logic [3:0] PRESS,
  output logic [3:0] RELEASE,
  output logic [7:0] PRESS_COUNT
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [7:0] popcount4(input logic [3:0] v);
    logic [7:0] sum;
    sum = 8'd0;
    for (int k = 0; k < 4; k++) begin
      sum = sum + {7'd0, v[k]};
    end
    return sum;
  endfunction

  logic [3:0]       w_btn_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] w_cnt_nxt [4];
  logic [3:0]       w_mismatch;
  logic [3:0]       w_expire;
  logic [3:0]       r_state;
  logic [3:0]       r_press;
  logic [3:0]       r_release;
  logic [7:0]       r_press_count;

  // Internal polarity: 1 means pressed for every button.
  assign w_btn_raw = {BTN3, BTN2, BTN1, ~BTN_N};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A counter runs only while the synchronised level disagrees with the
  // accepted level; reaching the last count accepts the change and restarts.
  always_comb begin
    w_mismatch = r_sync2 ^ r_state;
    w_expire   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i] = '0;
      if (!w_mismatch[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == LP_CNT_LAST) begin
        w_expire[i]  = 1'b1;
        w_cnt_nxt[i] = '0;
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
      r_state   <= 4'b0000;
      r_press   <= 4'b0000;
      r_release <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_state   <= r_state ^ w_expire;
      r_press   <= w_expire & ~r_state;
      r_release <= w_expire & r_state;
    end
  end

  // The total trails the pulses by one cycle and wraps modulo 256.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_press_count <= 8'd0;
    end else begin
      r_press_count <= r_press_count + popcount4(r_press);
    end
  end

  assign BTN_STATE   = r_state;
  assign PRESS       = r_press;
  assign RELEASE     = r_release;
  assign PRESS_COUNT = r_press_count;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce with DEBOUNCE_CYCLES=4: expected
// press/release events are queued with their edge index and matched in order.
module tb_button_debounce;

  localparam int D  = 4;
  localparam int CW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       btn1 = 1'b0;
  logic       btn2 = 1'b0;
  logic       btn3 = 1'b0;
  logic [3:0] btn_state;
  logic [3:0] press;
  logic [3:0] rel_o;
  logic [7:0] press_count;

  typedef struct packed {
    logic [15:0] edge_n;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  state;
    logic [7:0]  cnt_next;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  pend;
  ev_t  ex;
  ev_t  ob;
  logic pend_valid = 1'b0;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt;

  button_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .CLK(clk), .RST_N(rst_n), .BTN_N(btn_n), .BTN1(btn1), .BTN2(btn2), .BTN3(btn3),
    .BTN_STATE(btn_state), .PRESS(press), .RELEASE(rel_o), .PRESS_COUNT(press_count)
  );

  always #5 clk = ~clk;

  // Step n edges, recording each pulse with the press total seen one cycle later.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      if (pend_valid) begin
        pend.cnt_next = press_count;
        obs_q.push_back(pend);
        pend_valid = 1'b0;
      end
      if ((press | rel_o) != 4'b0000) begin
        pend.edge_n   = edge_cnt[15:0];
        pend.press    = press;
        pend.rel      = rel_o;
        pend.state    = btn_state;
        pend.cnt_next = 8'd0;
        pend_valid    = 1'b1;
      end
    end
  endtask

  task automatic push_exp(input int e, input logic [3:0] p, input logic [3:0] r,
                          input logic [3:0] s, input logic [7:0] c);
    ev_t x;
    x.edge_n = e[15:0]; x.press = p; x.rel = r; x.state = s; x.cnt_next = c;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    run_cycles(2);
    checks++; if (btn_state !== 4'b0000) begin errors++; $display("FAIL reset_state got=%b exp=0000", btn_state); end
    checks++; if (press !== 4'b0000) begin errors++; $display("FAIL reset_press got=%b exp=0000", press); end
    checks++; if (rel_o !== 4'b0000) begin errors++; $display("FAIL reset_release got=%b exp=0000", rel_o); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", press_count); end
    rst_n = 1'b1;
    edge_cnt = 0;
    run_cycles(10);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_release_pulse events=%0d exp=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    edge_cnt = 0;
    btn2 = 1'b1;
    run_cycles(3);
    btn2 = 1'b0;
    run_cycles(10);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_events events=%0d exp=0", obs_q.size()); end
    checks++; if (btn_state !== 4'b0000) begin errors++; $display("FAIL glitch_state got=%b exp=0000", btn_state); end
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL glitch_count got=%0d exp=0", press_count); end
    obs_q.delete();
  endtask

  task automatic test_clean_press();
    edge_cnt = 0;
    btn1 = 1'b1;
    push_exp(2 + D, 4'b0010, 4'b0000, 4'b0010, 8'd1);
    run_cycles(12);
    edge_cnt = 0;
    btn1 = 1'b0;
    push_exp(2 + D, 4'b0000, 4'b0010, 4'b0000, 8'd1);
    run_cycles(12);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clean_press_nevents got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL clean_press_ev got edge=%0d press=%b rel=%b state=%b cnt=%0d exp edge=%0d press=%b rel=%b state=%b cnt=%0d", ob.edge_n, ob.press, ob.rel, ob.state, ob.cnt_next, ex.edge_n, ex.press, ex.rel, ex.state, ex.cnt_next); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bounce();
    edge_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      btn_n = ~btn_n;
      run_cycles(1);
    end
    btn_n = 1'b0;
    push_exp(10 + 2 + D, 4'b0001, 4'b0000, 4'b0001, 8'd2);
    run_cycles(12);
    edge_cnt = 0;
    btn_n = 1'b1;
    push_exp(2 + D, 4'b0000, 4'b0001, 4'b0000, 8'd2);
    run_cycles(12);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bounce_nevents got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL bounce_ev got edge=%0d press=%b rel=%b state=%b cnt=%0d exp edge=%0d press=%b rel=%b state=%b cnt=%0d", ob.edge_n, ob.press, ob.rel, ob.state, ob.cnt_next, ex.edge_n, ex.press, ex.rel, ex.state, ex.cnt_next); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_count_fill();
    exp_cnt = 8'd2;
    for (int r = 0; r < 63; r++) begin
      edge_cnt = 0;
      {btn3, btn2, btn1, btn_n} = 4'b1110;
      exp_cnt = exp_cnt + 8'd4;
      push_exp(2 + D, 4'b1111, 4'b0000, 4'b1111, exp_cnt);
      run_cycles(12);
      edge_cnt = 0;
      {btn3, btn2, btn1, btn_n} = 4'b0001;
      push_exp(2 + D, 4'b0000, 4'b1111, 4'b0000, exp_cnt);
      run_cycles(12);
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_nevents got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL fill_ev got edge=%0d press=%b rel=%b state=%b cnt=%0d exp edge=%0d press=%b rel=%b state=%b cnt=%0d", ob.edge_n, ob.press, ob.rel, ob.state, ob.cnt_next, ex.edge_n, ex.press, ex.rel, ex.state, ex.cnt_next); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (press_count !== 8'd254) begin errors++; $display("FAIL fill_total got=%0d exp=254", press_count); end
  endtask

  task automatic test_simultaneous();
    edge_cnt = 0;
    {btn3, btn2, btn1} = 3'b111;
    push_exp(2 + D, 4'b1110, 4'b0000, 4'b1110, 8'd1);
    run_cycles(12);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL simul_nevents got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL simul_ev got edge=%0d press=%b rel=%b state=%b cnt=%0d exp edge=%0d press=%b rel=%b state=%b cnt=%0d", ob.edge_n, ob.press, ob.rel, ob.state, ob.cnt_next, ex.edge_n, ex.press, ex.rel, ex.state, ex.cnt_next); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_release();
    edge_cnt = 0;
    btn3 = 1'b0;
    push_exp(2 + D, 4'b0000, 4'b1000, 4'b0110, 8'd1);
    run_cycles(12);
    edge_cnt = 0;
    {btn2, btn1} = 2'b00;
    push_exp(2 + D, 4'b0000, 4'b0110, 4'b0000, 8'd1);
    run_cycles(12);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL release_nevents got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL release_ev got edge=%0d press=%b rel=%b state=%b cnt=%0d exp edge=%0d press=%b rel=%b state=%b cnt=%0d", ob.edge_n, ob.press, ob.rel, ob.state, ob.cnt_next, ex.edge_n, ex.press, ex.rel, ex.state, ex.cnt_next); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    edge_cnt = 0;
    btn1 = 1'b1;
    run_cycles(4);
    rst_n = 1'b0;
    #1;
    checks++; if (press_count !== 8'd0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", press_count); end
    checks++; if ({btn_state, press, rel_o} !== 12'd0) begin errors++; $display("FAIL midreset_outputs got=%b exp=0", {btn_state, press, rel_o}); end
    run_cycles(3);
    rst_n = 1'b1;
    edge_cnt = 0;
    push_exp(2 + D, 4'b0010, 4'b0000, 4'b0010, 8'd1);
    run_cycles(12);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_nevents got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      ex = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (ob !== ex) begin errors++; $display("FAIL midreset_ev got edge=%0d press=%b rel=%b state=%b cnt=%0d exp edge=%0d press=%b rel=%b state=%b cnt=%0d", ob.edge_n, ob.press, ob.rel, ob.state, ob.cnt_next, ex.edge_n, ex.press, ex.rel, ex.state, ex.cnt_next); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_bounce();
    test_count_fill();
    test_simultaneous();
    test_release();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
